spu_issue_scheduler: RTL and testbench

Single-issue dispatch and hazard scheduler for the SPU dual-pipe datapath. It sits between instruction decode and the even pipe (fixed/float/byte) and the odd pipe (load-store/permute/branch). It holds each decoded instruction until there is no RAW or WAW hazard on the 128-entry register file, the shared register-file write port is free in the result's writeback cycle, and the target pipe can accept it. It then issues the instruction and tracks the pending write.

---
 rtl/spu_issue_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_spu_issue_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_issue_scheduler.sv
// spu_issue_scheduler
// Single-issue dispatch and hazard scheduler for the SPU dual-pipe datapath.
// A decoded instruction is accepted only when its sources have no pending
// writes (RAW), its destination has no pending write (WAW), the shared
// register-file write port is free in its writeback cycle and the target
// pipe is not stalled. Accepted instructions are presented on the registered
// iss_* outputs one cycle later, and the pending write is tracked until it
// reaches the write port.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_in_valid       decoded instruction present
//   o_in_ready       accept this cycle (combinational)
//   i_in_pipe        0 = even pipe, 1 = odd pipe
//   i_in_op          11-bit normalised opcode
//   i_in_ra/rb/rc    source registers
//   i_in_use         source-used mask {rc,rb,ra}
//   i_in_rt          destination register
//   i_in_wr          instruction writes i_in_rt
//   i_in_lat         cycles from accept to writeback (0 behaves as 1)
//   i_ev_stall       even pipe cannot accept
//   i_od_stall       odd pipe cannot accept
//   i_flush          branch redirect, blocks accept
//   o_iss_*          registered issue strobe and fields
//   o_wb_due         shared write port used this cycle
//   o_wb_rt          register written when o_wb_due is high
//   o_stall_cnt      saturating count of blocked cycles
module spu_issue_scheduler #(
  parameter int NREG = 128,
  parameter int RW   = 7,
  parameter int LATW = 3,
  parameter int SCW  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic            i_in_pipe,
  input  logic [10:0]     i_in_op,
  input  logic [RW-1:0]   i_in_ra,
  input  logic [RW-1:0]   i_in_rb,
  input  logic [RW-1:0]   i_in_rc,
  input  logic [2:0]      i_in_use,
  input  logic [RW-1:0]   i_in_rt,
  input  logic            i_in_wr,
  input  logic [LATW-1:0] i_in_lat,
  input  logic            i_ev_stall,
  input  logic            i_od_stall,
  input  logic            i_flush,
  output logic            o_iss_valid,
  output logic            o_iss_pipe,
  output logic [10:0]     o_iss_op,
  output logic [RW-1:0]   o_iss_ra,
  output logic [RW-1:0]   o_iss_rb,
  output logic [RW-1:0]   o_iss_rc,
  output logic [RW-1:0]   o_iss_rt,
  output logic            o_wb_due,
  output logic [RW-1:0]   o_wb_rt,
  output logic [SCW-1:0]  o_stall_cnt
);

  // Slot k of the reservation vector stands for the write port k cycles
  // from now; the largest latency needs slot 2^LATW-2 after the first shift.
  localparam int NSLOT = (2 ** LATW) - 1;

  logic [LATW-1:0] r_cnt [NREG];
  logic [NSLOT-1:0] r_resv;
  logic [RW-1:0]   r_tag [NSLOT];
  logic [SCW-1:0]  r_stall_cnt;

  logic [LATW-1:0] w_lat;
  logic            w_src_busy;
  logic            w_rt_busy;
  logic            w_port_busy;
  logic            w_pipe_stall;
  logic            w_accept;
  logic            w_wr_acc;
  logic [NSLOT:0]  w_resv_ext;
  logic [NSLOT-1:0] w_resv_nxt;
  logic [RW-1:0]   w_tag_nxt [NSLOT];

  always_comb begin
    w_lat = (i_in_lat == '0) ? LATW'(1) : i_in_lat;

    w_src_busy = (i_in_use[0] && (r_cnt[i_in_ra] != '0)) ||
                 (i_in_use[1] && (r_cnt[i_in_rb] != '0)) ||
                 (i_in_use[2] && (r_cnt[i_in_rc] != '0));
    w_rt_busy  = i_in_wr && (r_cnt[i_in_rt] != '0);

    // The port slot for cycle t+L is R[L]; L = 2^LATW-1 looks one past the
    // top of the vector, which is always free.
    w_resv_ext  = {1'b0, r_resv};
    w_port_busy = i_in_wr && w_resv_ext[w_lat];

    w_pipe_stall = i_in_pipe ? i_od_stall : i_ev_stall;
    w_accept     = i_in_valid && !i_flush && !w_pipe_stall &&
                   !w_src_busy && !w_rt_busy && !w_port_busy;
    w_wr_acc     = w_accept && i_in_wr;
  end

  assign o_in_ready = w_accept;

  always_comb begin
    w_resv_nxt = r_resv >> 1;
    for (int k = 0; k < NSLOT - 1; k++) begin
      w_tag_nxt[k] = r_tag[k+1];
    end
    w_tag_nxt[NSLOT-1] = '0;
    if (w_wr_acc) begin
      // Slot L-1 after this shift lands in R[0] exactly L cycles from now.
      w_resv_nxt[w_lat - 1'b1] = 1'b1;
      w_tag_nxt[w_lat - 1'b1]  = i_in_rt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr_acc && (i_in_rt == RW'(i))) begin
          r_cnt[i] <= w_lat;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resv <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_resv <= w_resv_nxt;
      for (int k = 0; k < NSLOT; k++) begin
        r_tag[k] <= w_tag_nxt[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_in_valid && !w_accept && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_iss_valid <= 1'b0;
      o_iss_pipe  <= 1'b0;
      o_iss_op    <= '0;
      o_iss_ra    <= '0;
      o_iss_rb    <= '0;
      o_iss_rc    <= '0;
      o_iss_rt    <= '0;
    end else begin
      o_iss_valid <= w_accept;
      if (w_accept) begin
        o_iss_pipe <= i_in_pipe;
        o_iss_op   <= i_in_op;
        o_iss_ra   <= i_in_ra;
        o_iss_rb   <= i_in_rb;
        o_iss_rc   <= i_in_rc;
        o_iss_rt   <= i_in_rt;
      end
    end
  end

  assign o_wb_due    = r_resv[0];
  assign o_wb_rt     = r_tag[0];
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_spu_issue_scheduler.sv
module tb_spu_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_pipe, wr, ev_stall, od_stall, flush;
  logic [10:0] in_op;
  logic [6:0]  ra, rb, rc, rt;
  logic [2:0]  use_m, lat;
  logic        in_ready, iss_valid, iss_pipe, wb_due;
  logic [10:0] iss_op;
  logic [6:0]  iss_ra, iss_rb, iss_rc, iss_rt, wb_rt;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  spu_issue_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_pipe(in_pipe), .i_in_op(in_op), .i_in_ra(ra), .i_in_rb(rb), .i_in_rc(rc),
    .i_in_use(use_m), .i_in_rt(rt), .i_in_wr(wr), .i_in_lat(lat),
    .i_ev_stall(ev_stall), .i_od_stall(od_stall), .i_flush(flush),
    .o_iss_valid(iss_valid), .o_iss_pipe(iss_pipe), .o_iss_op(iss_op),
    .o_iss_ra(iss_ra), .o_iss_rb(iss_rb), .o_iss_rc(iss_rc), .o_iss_rt(iss_rt),
    .o_wb_due(wb_due), .o_wb_rt(wb_rt), .o_stall_cnt(stall_cnt)
  );

  // Reference model: absolute cycle at which each register becomes readable,
  // and a map from absolute writeback cycle to the register written then.
  int          free_at [128];
  int          port_tag [int];
  int          stall_m;
  bit          exp_iss_v;
  logic        e_pipe;
  logic [10:0] e_op;
  logic [6:0]  e_ra, e_rb, e_rc, e_rt;
  int          cyc;
  int          n_cmp, n_err;
  bit          dut_rdy, dut_wb;

  typedef struct {
    bit         valid;
    bit         pipe;
    bit         wr;
    logic [2:0] lat;
    bit         ev_s;
    bit         od_s;
    bit         fl;
    bit         rdy;
    int         wb;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit model_ready();
    bit ok;
    int L;
    ok = in_valid && !flush && !(in_pipe ? od_stall : ev_stall);
    if (use_m[0] && cyc < free_at[ra]) ok = 0;
    if (use_m[1] && cyc < free_at[rb]) ok = 0;
    if (use_m[2] && cyc < free_at[rc]) ok = 0;
    if (wr) begin
      L = (lat == 0) ? 1 : int'(lat);
      if (cyc < free_at[rt]) ok = 0;
      if (port_tag.exists(cyc + L)) ok = 0;
    end
    return ok;
  endfunction

  task automatic model_clear();
    foreach (free_at[i]) free_at[i] = 0;
    port_tag.delete();
    stall_m   = 0;
    exp_iss_v = 0;
  endtask

  task automatic idle();
    in_valid = 0; in_pipe = 0; in_op = 0; ra = 0; rb = 0; rc = 0;
    use_m = 0; rt = 0; wr = 0; lat = 0; ev_stall = 0; od_stall = 0; flush = 0;
  endtask

  task automatic set_instr(input bit p, input int op, input int a, input int b,
                           input int c, input int u, input int t, input bit w,
                           input int l);
    in_valid = 1; in_pipe = p; in_op = 11'(op); ra = 7'(a); rb = 7'(b);
    rc = 7'(c); use_m = 3'(u); rt = 7'(t); wr = w; lat = 3'(l);
  endtask

  // Entered at posedge+1; checks the current cycle, advances the model and
  // returns at the next posedge+1.
  task automatic step();
    bit ok;
    int L;
    #2;
    ok      = model_ready();
    dut_rdy = in_ready;
    dut_wb  = wb_due;
    chk("in_ready", int'(in_ready), int'(ok));
    chk("iss_valid", int'(iss_valid), int'(exp_iss_v));
    if (exp_iss_v) begin
      chk("iss_pipe", int'(iss_pipe), int'(e_pipe));
      chk("iss_op", int'(iss_op), int'(e_op));
      chk("iss_ra", int'(iss_ra), int'(e_ra));
      chk("iss_rb", int'(iss_rb), int'(e_rb));
      chk("iss_rc", int'(iss_rc), int'(e_rc));
      chk("iss_rt", int'(iss_rt), int'(e_rt));
    end
    chk("wb_due", int'(wb_due), int'(port_tag.exists(cyc)));
    if (port_tag.exists(cyc)) begin
      chk("wb_rt", int'(wb_rt), port_tag[cyc]);
      port_tag.delete(cyc);
    end
    chk("stall_cnt", int'(stall_cnt), stall_m);
    if (in_valid && !ok && stall_m < 65535) stall_m++;
    exp_iss_v = ok;
    if (ok) begin
      e_pipe = in_pipe; e_op = in_op; e_ra = ra; e_rb = rb; e_rc = rc; e_rt = rt;
      if (wr) begin
        L = (lat == 0) ? 1 : int'(lat);
        free_at[rt] = cyc + L + 1;
        port_tag[cyc + L] = int'(rt);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    #1;
    chk("rst_iss_valid", int'(iss_valid), 0);
    chk("rst_iss_rt", int'(iss_rt), 0);
    chk("rst_iss_op", int'(iss_op), 0);
    chk("rst_wb_due", int'(wb_due), 0);
    chk("rst_wb_rt", int'(wb_rt), 0);
    chk("rst_stall", int'(stall_cnt), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc++;
  endtask

  initial begin
    int acc, wbc;
    bit pend;
    n_cmp = 0; n_err = 0; cyc = 0;
    model_clear();
    rst_n = 1;
    idle();

    tbl[0] = '{1, 0, 1, 3'd2, 0, 0, 0, 1, 2};
    tbl[1] = '{1, 1, 1, 3'd0, 0, 0, 0, 1, 1};
    tbl[2] = '{1, 1, 1, 3'd3, 0, 1, 0, 0, -1};
    tbl[3] = '{1, 0, 1, 3'd3, 1, 0, 0, 0, -1};
    tbl[4] = '{1, 0, 1, 3'd7, 0, 1, 0, 1, 7};
    tbl[5] = '{1, 1, 1, 3'd5, 1, 0, 0, 1, 5};
    tbl[6] = '{1, 0, 1, 3'd4, 0, 0, 1, 0, -1};
    tbl[7] = '{1, 0, 0, 3'd3, 0, 0, 0, 1, -1};
    tbl[8] = '{0, 0, 1, 3'd1, 0, 0, 0, 0, -1};
    #1;

    // Single instructions from a clean state
    foreach (tbl[i]) begin
      do_reset();
      set_instr(tbl[i].pipe, 100 + i, 1, 2, 3, 7, 20 + i, tbl[i].wr, int'(tbl[i].lat));
      in_valid = tbl[i].valid;
      ev_stall = tbl[i].ev_s; od_stall = tbl[i].od_s; flush = tbl[i].fl;
      step();
      chk("tbl_rdy", int'(dut_rdy), int'(tbl[i].rdy));
      chk("tbl_iss", int'(iss_valid), int'(tbl[i].rdy));
      idle();
      wbc = -1;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (dut_wb && wbc < 0) wbc = k;
      end
      chk("tbl_wb", wbc, tbl[i].wb);
    end

    // Basic issue and writeback timing
    do_reset();
    set_instr(0, 11, 0, 0, 0, 0, 5, 1, 2);
    step();
    chk("a_acc", int'(dut_rdy), 1);
    chk("a_iss_valid", int'(iss_valid), 1);
    chk("a_iss_rt", int'(iss_rt), 5);
    idle();
    step();
    chk("a_wb_due", int'(wb_due), 1);
    chk("a_wb_rt", int'(wb_rt), 5);
    step();
    step();

    // RAW hold
    do_reset();
    set_instr(0, 12, 0, 0, 0, 0, 5, 1, 4);
    step();
    set_instr(0, 13, 5, 0, 0, 1, 0, 0, 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("raw_block", int'(dut_rdy), 0);
    end
    step();
    chk("raw_acc", int'(dut_rdy), 1);
    chk("raw_stall", int'(stall_cnt), 4);
    idle();
    step();

    // Write-port conflict
    do_reset();
    set_instr(0, 14, 0, 0, 0, 0, 1, 1, 3);
    step();
    set_instr(1, 15, 0, 0, 0, 0, 2, 1, 2);
    step();
    chk("port_block", int'(dut_rdy), 0);
    step();
    chk("port_acc", int'(dut_rdy), 1);
    chk("port_wb3", int'(wb_due), 1);
    chk("port_wbrt3", int'(wb_rt), 1);
    idle();
    step();
    chk("port_wb4", int'(wb_due), 1);
    chk("port_wbrt4", int'(wb_rt), 2);
    step();

    // Pipe stall and flush with an earlier write in flight
    do_reset();
    set_instr(0, 16, 0, 0, 0, 0, 3, 1, 3);
    step();
    set_instr(1, 17, 0, 0, 0, 0, 0, 0, 1);
    od_stall = 1;
    step();
    chk("odstall_block", int'(dut_rdy), 0);
    set_instr(0, 18, 0, 0, 0, 0, 4, 1, 1);
    od_stall = 0; flush = 1;
    step();
    chk("flush_block", int'(dut_rdy), 0);
    chk("flush_iss", int'(iss_valid), 0);
    chk("flush_wb", int'(wb_due), 1);
    chk("flush_wbrt", int'(wb_rt), 3);
    idle();
    step();

    // WAW with zero latency field
    do_reset();
    set_instr(0, 19, 0, 0, 0, 0, 9, 1, 7);
    step();
    set_instr(0, 20, 0, 0, 0, 0, 9, 1, 0);
    acc = -1;
    for (int k = 1; k <= 20 && acc < 0; k++) begin
      step();
      if (dut_rdy) acc = k;
    end
    chk("waw_acc", acc, 8);
    idle();
    chk("waw_wb", int'(wb_due), 1);
    chk("waw_wbrt", int'(wb_rt), 9);
    step();

    // Reset in the middle of three pending writes
    do_reset();
    set_instr(0, 21, 0, 0, 0, 0, 10, 1, 7);
    step();
    set_instr(1, 22, 0, 0, 0, 0, 11, 1, 7);
    step();
    set_instr(0, 23, 0, 0, 0, 0, 12, 1, 7);
    step();
    chk("pre_rst_iss", int'(iss_valid), 1);
    do_reset();
    set_instr(0, 24, 10, 11, 12, 7, 0, 0, 1);
    step();
    chk("post_rst_acc", int'(dut_rdy), 1);
    idle();
    step();

    // Randomized traffic against the model
    pend = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        pend = 0;
      end
      if (!pend) begin
        set_instr($urandom_range(0, 1), $urandom_range(0, 2047),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 9) < 8), $urandom_range(0, 7));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      ev_stall = ($urandom_range(0, 4) == 0);
      od_stall = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      pend     = in_valid;
      step();
      if (dut_rdy) pend = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
